// File: rtl/game_timer_display.sv
// Hex decoder: 4-bit value to active-low 7-segment pattern, bit0=a .. bit6=g.
// Latency: purely combinational.
// Backpressure: none.
module hex_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// Game step / 1 s tick generator with an MM:SS BCD elapsed-time display (TIMER_SATURATE_EN: hold at 99:59).
// Latency: ticks and display update one cycle after the terminal divider count.
// Backpressure: none; enable low freezes dividers and time, ticks forced low.
module game_timer_display #(
  parameter int FAST_DIV = 2500000,
  parameter int SEC_DIV  = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  output logic       fast_tick,
  output logic       sec_tick,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);
  localparam int FW = $clog2(FAST_DIV);
  localparam int SW = $clog2(SEC_DIV);
  localparam logic [FW-1:0] FAST_MAX = FW'(FAST_DIV - 1);
  localparam logic [SW-1:0] SEC_MAX  = SW'(SEC_DIV - 1);

  logic [FW-1:0] fast_cnt;
  logic [SW-1:0] sec_cnt;
  logic [3:0]    s0, s1, m0, m1;
  logic [3:0]    s0_n, s1_n, m0_n, m1_n;
  logic          sec_wrap;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      fast_cnt  <= '0;
      fast_tick <= 1'b0;
    end else if (!enable) begin
      fast_tick <= 1'b0;
    end else if (fast_cnt == FAST_MAX) begin
      fast_cnt  <= '0;
      fast_tick <= 1'b1;
    end else begin
      fast_cnt  <= fast_cnt + FW'(1);
      fast_tick <= 1'b0;
    end
  end

  assign sec_wrap = enable && (sec_cnt == SEC_MAX);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sec_cnt  <= '0;
      sec_tick <= 1'b0;
    end else if (!enable) begin
      sec_tick <= 1'b0;
    end else if (sec_wrap) begin
      sec_cnt  <= '0;
      sec_tick <= 1'b1;
    end else begin
      sec_cnt  <= sec_cnt + SW'(1);
      sec_tick <= 1'b0;
    end
  end

  // BCD increment with ripple carry s0 -> s1 -> m0 -> m1.
  always_comb begin
    s0_n = s0;
    s1_n = s1;
    m0_n = m0;
    m1_n = m1;
    if (s0 != 4'd9) begin
      s0_n = s0 + 4'd1;
    end else begin
      s0_n = 4'd0;
      if (s1 != 4'd5) begin
        s1_n = s1 + 4'd1;
      end else begin
        s1_n = 4'd0;
        if (m0 != 4'd9) begin
          m0_n = m0 + 4'd1;
        end else begin
          m0_n = 4'd0;
          m1_n = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
        end
      end
    end
`ifdef TIMER_SATURATE_EN
    if (m1 == 4'd9 && m0 == 4'd9 && s1 == 4'd5 && s0 == 4'd9) begin
      s0_n = s0;
      s1_n = s1;
      m0_n = m0;
      m1_n = m1;
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s0 <= 4'd0;
      s1 <= 4'd0;
      m0 <= 4'd0;
      m1 <= 4'd0;
    end else if (sec_wrap) begin
      s0 <= s0_n;
      s1 <= s1_n;
      m0 <= m0_n;
      m1 <= m1_n;
    end
  end

  hex_decoder u_hex0 (.digit(s0), .seg(HEX0));
  hex_decoder u_hex1 (.digit(s1), .seg(HEX1));
  hex_decoder u_hex2 (.digit(m0), .seg(HEX2));
  hex_decoder u_hex3 (.digit(m1), .seg(HEX3));
endmodule

// File: tb/tb_game_timer_display.sv
// Bench for game_timer_display with FAST_DIV=4, SEC_DIV=10 against an elapsed-edge-count reference model.
module tb_game_timer_display;
  localparam int FD = 4;
  localparam int SD = 10;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [27:0] ZERO_DISP = {4{7'b1000000}};

  logic       CLOCK_50;
  logic       resetn;
  logic       enable;
  logic       fast_tick, sec_tick;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic [3:0] dec_in;
  logic [6:0] dec_seg;

  int   tests = 0;
  int   fails = 0;
  int   e = 0;          // enabled edges since reset release
  logic last_en = 1'b0;

  game_timer_display #(.FAST_DIV(FD), .SEC_DIV(SD)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable),
    .fast_tick(fast_tick), .sec_tick(sec_tick),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  hex_decoder u_dec (.digit(dec_in), .seg(dec_seg));

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] disp_of(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {SEG_TAB[m / 10], SEG_TAB[m % 10], SEG_TAB[s / 10], SEG_TAB[s % 10]};
  endfunction

  function automatic int shown_secs();
`ifdef TIMER_SATURATE_EN
    return (e / SD > 5999) ? 5999 : e / SD;
`else
    return (e / SD) % 6000;
`endif
  endfunction

  task automatic check_model();
    logic [1:0] exp_t;
    exp_t[1] = last_en && (e > 0) && (e % FD == 0);
    exp_t[0] = last_en && (e > 0) && (e % SD == 0);
    chk("ticks", {30'd0, fast_tick, sec_tick}, {30'd0, exp_t});
    chk("display", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, disp_of(shown_secs())});
  endtask

  task automatic step(input logic en);
    enable = en;
    @(posedge CLOCK_50);
    if (en) e++;
    last_en = en;
    @(negedge CLOCK_50);
    check_model();
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    enable = 1'b1;
    dec_in = 4'd0;
    repeat (3) @(negedge CLOCK_50);
    chk("reset_disp", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, ZERO_DISP});
    chk("reset_ticks", {30'd0, fast_tick, sec_tick}, 32'd0);
    resetn = 1'b1;

    repeat (100) step(1'b1);
    chk("disp_00_10", {4'd0, HEX3, HEX2, HEX1, HEX0},
        {4'd0, 7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000});
    repeat (500) step(1'b1);
    chk("disp_01_00", {4'd0, HEX3, HEX2, HEX1, HEX0},
        {4'd0, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000});

    // Pause at 3 edges into a second; 7 more enabled edges should finish it.
    n = 0;
    while (e % SD != 3 && n < 20) begin step(1'b1); n++; end
    repeat (25) step(1'b0);
    n = 0;
    do begin step(1'b1); n++; end while (!sec_tick && n < 20);
    chk("resume_gap", n, 7);

    repeat (300) step($urandom_range(0, 3) != 0);

    // Asynchronous reset between edges, with fast_tick high and digits nonzero.
    n = 0;
    do begin step(1'b1); n++; end while (!fast_tick && n < 10);
    #2 resetn = 1'b0;
    #1;
    chk("async_disp", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, ZERO_DISP});
    chk("async_ticks", {30'd0, fast_tick, sec_tick}, 32'd0);
    e = 0;
    last_en = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (25) step(1'b1);

    while (e < 5999 * SD) step(1'b1);
    chk("disp_99_59", {4'd0, HEX3, HEX2, HEX1, HEX0},
        {4'd0, 7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000});
    repeat (SD) step(1'b1);
`ifdef TIMER_SATURATE_EN
    chk("after_99_59", {4'd0, HEX3, HEX2, HEX1, HEX0},
        {4'd0, 7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000});
`else
    chk("after_99_59", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, ZERO_DISP});
`endif
    repeat (25) step(1'b1);

    for (int i = 0; i < 16; i++) begin
      dec_in = 4'(i);
      #1;
      chk("decoder", {25'd0, dec_seg}, {25'd0, SEG_TAB[i]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_timer_display.md
Name: game_timer_display

Overview:
- Game-side timing and score-clock block for the tron game top level.
- Divides CLOCK_50 into a fast game-step tick and a 1 s tick.
- Keeps an elapsed-time count as MM:SS BCD and drives four active-low 7-segment displays (HEX3..HEX0) through an internal hex decoder.
- Enable input (SW[17] at top level) pauses both the ticks and the clock.

Parameters:
- FAST_DIV, 2500000: CLOCK_50 cycles per fast_tick pulse (20 Hz game step); legal range 2 or more.
- SEC_DIV, 50000000: CLOCK_50 cycles per sec_tick pulse (1 Hz); legal range 2 or more.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  high = run; low = pause dividers and time count.
- fast_tick  out  1  one-cycle pulse every FAST_DIV enabled cycles; game-step strobe.
- sec_tick  out  1  one-cycle pulse every SEC_DIV enabled cycles.
- HEX0  out  7  seconds ones digit, active-low segments, bit0=a through bit6=g.
- HEX1  out  7  seconds tens digit, same encoding.
- HEX2  out  7  minutes ones digit, same encoding.
- HEX3  out  7  minutes tens digit, same encoding.

Behaviour:
- Reset (resetn=0, asynchronous, dominant over everything):
  - fast and second divider counters = 0.
  - fast_tick = 0, sec_tick = 0.
  - All four BCD digits = 0, so every HEX output = 7'b1000000.
  - Takes effect immediately, including mid-count. Counting restarts from 0 on the first rising edge after release.
- Fast divider:
  - Counter runs 0..FAST_DIV-1 while enable=1.
  - On the edge where counter == FAST_DIV-1: counter returns to 0 and fast_tick is registered high for exactly the following cycle.
  - First pulse appears FAST_DIV enabled edges after reset release.
- Second divider:
  - Same structure with SEC_DIV, producing sec_tick.
  - On that same edge the time count increments, so the HEX outputs and sec_tick change together.
- enable=0:
  - Both counters and all digits hold their values; ticks are forced to 0.
  - Resuming continues from the held count (no restart).
- Time count, BCD, digits s0, s1, m0, m1:
  - s0 counts 0..9; on rollover it returns to 0 and carries into s1.
  - s1 counts 0..5; on 59 -> 00 it carries into m0.
  - m0 counts 0..9; on rollover it carries into m1.
  - m1 counts 0..9.
  - 99:59 wraps to 00:00.
  - Digits never hold a non-BCD value.
- Hex decoder:
  - Purely combinational, one instance per digit; accepts a 4-bit value 0..F.
  - Encoding, active-low, listed as g..a:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
  - Only 0..9 occur in normal operation; A..F must still decode correctly.
- No latches; all counters use widths sized as ceil(log2(DIV)).

Optional Feature:
- Macro TIMER_SATURATE_EN.
- Defined: the time count stops at 99:59 and holds there until reset. sec_tick keeps pulsing.
- Undefined: 99:59 wraps to 00:00 on the next sec_tick.

Test Plan (bench overrides FAST_DIV=4, SEC_DIV=10):
- Reset held low, then released with enable=1 -> HEX3..HEX0 all 1000000; fast_tick first high at the cycle after the 4th edge, then every 4 cycles; sec_tick every 10 cycles.
- Run 10 sec_ticks from reset -> digits show 00:10 (HEX1=1111001, HEX0=1000000); run 50 more -> 01:00 (HEX2=1111001, HEX1=HEX0=1000000).
- Drop enable for 25 cycles mid-count -> no ticks, digits and counters unchanged; after enable rises, the next sec_tick arrives after the remaining count, not a full 10.
- Preload to 99:59 by running 5999 sec_ticks, then one more -> 00:00. With TIMER_SATURATE_EN defined -> stays 99:59.
- Assert resetn low asynchronously between edges mid-count -> outputs clear immediately without a clock edge.
- Drive the decoder directly with 0..F -> matches the encoding list for all 16 values.
